// File: rtl/dm_access_unit.sv
// Data-memory access unit: aligns stores onto byte lanes, runs the req/gnt/rvalid
// handshake and stalls the pipeline until the load data is registered.
module dm_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_MEM,
  input  logic        mem_wr_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] store_data_MEM,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] DM_OUT,
  output logic        stall_mem,
  output logic        misalign_exc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = XLEN / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef struct packed {
    logic [XLEN-3:0]  word_addr;
    logic [LANES-1:0] we;
    logic [XLEN-1:0]  wdata;
    logic [1:0]       off;
    logic             is_load;
  } req_t;

  logic [1:0]       state, state_nxt;
  req_t             req_q, req_d;
  logic             latch_c, capture_c;
  logic             access_c, is_store_c, misaligned_c;
  logic [1:0]       size_c, off_c;
  logic [LANES-1:0] we_c;
  logic [XLEN-1:0]  wdata_c;

  assign access_c   = mem_rd_MEM | mem_wr_MEM;
  assign is_store_c = mem_wr_MEM;
  assign size_c     = funct3_MEM[1:0];
  assign off_c      = addr_MEM[1:0];
  assign misaligned_c = ((size_c == 2'b01) && off_c[0]) ||
                        ((size_c == 2'b10) && (off_c != 2'b00)) ||
                        (size_c == 2'b11);

  // Store lane steering; loads present no enables and zero data
  always_comb begin
    we_c    = '0;
    wdata_c = '0;
    if (is_store_c) begin
      case (size_c)
        2'b00: begin
          we_c    = LANES'(4'b0001 << off_c);
          wdata_c = {4{store_data_MEM[7:0]}};
        end
        2'b01: begin
          we_c    = LANES'(4'b0011 << off_c);
          wdata_c = {2{store_data_MEM[15:0]}};
        end
        2'b10: begin
          we_c    = 4'b1111;
          wdata_c = store_data_MEM;
        end
        default: begin
          we_c    = '0;
          wdata_c = '0;
        end
      endcase
    end
  end

  always_comb begin
    req_d.word_addr = addr_MEM[31:2];
    req_d.we        = we_c;
    req_d.wdata     = wdata_c;
    req_d.off       = off_c;
    req_d.is_load   = ~is_store_c;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt    = state;
    dm_req       = 1'b0;
    dm_we        = '0;
    dm_addr      = {req_q.word_addr, 2'b00};
    dm_wdata     = req_q.wdata;
    stall_mem    = 1'b0;
    misalign_exc = 1'b0;
    latch_c      = 1'b0;
    capture_c    = 1'b0;
    case (state)
      IDLE: begin
        dm_addr  = {addr_MEM[31:2], 2'b00};
        dm_wdata = wdata_c;
        if (access_c && misaligned_c) begin
          misalign_exc = 1'b1;
        end else if (access_c) begin
          dm_req    = 1'b1;
          dm_we     = we_c;
          stall_mem = 1'b1;
          latch_c   = 1'b1;
          if (dm_gnt) state_nxt = is_store_c ? DONE : RESP;
          else        state_nxt = REQ;
        end
      end
      REQ: begin
        dm_req    = 1'b1;
        dm_we     = req_q.we;
        stall_mem = 1'b1;
        if (dm_gnt) state_nxt = req_q.is_load ? RESP : DONE;
      end
      RESP: begin
        stall_mem = 1'b1;
        if (dm_rvalid) begin
          capture_c = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Quiet all handshake outputs while reset is held
    if (rst) begin
      dm_req       = 1'b0;
      dm_we        = '0;
      stall_mem    = 1'b0;
      misalign_exc = 1'b0;
      latch_c      = 1'b0;
      capture_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= '0;
      DM_OUT <= '0;
    end else begin
      state <= state_nxt;
      if (latch_c)   req_q  <= req_d;
      if (capture_c) DM_OUT <= dm_rdata >> {req_q.off, 3'b000};
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: vector table plus reset-abort sequence,
// load results tracked through a scoreboard queue.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_MEM, mem_wr_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM, store_data_MEM;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] DM_OUT;
  logic        stall_mem, misalign_exc;

  dm_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_rd_MEM(mem_rd_MEM), .mem_wr_MEM(mem_wr_MEM),
    .funct3_MEM(funct3_MEM), .addr_MEM(addr_MEM), .store_data_MEM(store_data_MEM),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .DM_OUT(DM_OUT), .stall_mem(stall_mem), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [3:0]  dly;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] daddr;
    logic [31:0] dout;
    logic [3:0]  stalls;
  } vec_t;

  localparam int NVEC = 13;
  vec_t        vecs [NVEC];
  logic [31:0] sb_q [$];
  logic [31:0] last_out;
  int          tests  = 0;
  int          failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_rd_MEM = 1'b0; mem_wr_MEM = 1'b0; funct3_MEM = 3'b000;
    addr_MEM = '0; store_data_MEM = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic        is_load;
    int          stalls;
    logic [31:0] exp_out;
    is_load = v.rd & ~v.wr;
    stalls  = 0;
    @(negedge clk);
    mem_rd_MEM = v.rd; mem_wr_MEM = v.wr; funct3_MEM = v.f3;
    addr_MEM = v.addr; store_data_MEM = v.sd;
    dm_gnt = (v.dly == 4'd0); dm_rvalid = 1'b0;
    #1;
    chk($sformatf("v%0d misalign_exc", idx), 32'(misalign_exc), 32'(v.mis));
    if (v.mis || !(v.rd || v.wr)) begin
      chk($sformatf("v%0d dm_req", idx), 32'(dm_req), 32'(1'b0));
      chk($sformatf("v%0d stall_mem", idx), 32'(stall_mem), 32'(1'b0));
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("v%0d DM_OUT held", idx), DM_OUT, last_out);
      chk($sformatf("v%0d stall after", idx), 32'(stall_mem), 32'(1'b0));
      return;
    end
    if (is_load) sb_q.push_back(v.dout);
    for (int k = 0; k <= int'(v.dly); k++) begin
      if (k > 0) begin
        @(negedge clk);
        dm_gnt = (k == int'(v.dly));
        #1;
      end
      chk($sformatf("v%0d c%0d dm_req", idx, k), 32'(dm_req), 32'(1'b1));
      chk($sformatf("v%0d c%0d dm_we", idx, k), 32'(dm_we), 32'(v.we));
      chk($sformatf("v%0d c%0d dm_wdata", idx, k), dm_wdata, v.wdata);
      chk($sformatf("v%0d c%0d dm_addr", idx, k), dm_addr, v.daddr);
      if (stall_mem) stalls++;
      // rvalid in the grant cycle must be ignored
      if (k == int'(v.dly) && is_load) begin
        dm_rvalid = 1'b1; dm_rdata = 32'h5555AAAA;
      end
      @(posedge clk);
    end
    @(negedge clk);
    dm_gnt = 1'b0;
    if (is_load) begin
      dm_rvalid = 1'b1; dm_rdata = v.rdata;
      #1;
      chk($sformatf("v%0d resp dm_req", idx), 32'(dm_req), 32'(1'b0));
      if (stall_mem) stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    dm_rvalid = 1'b0; dm_rdata = '0;
    #1;
    chk($sformatf("v%0d done stall", idx), 32'(stall_mem), 32'(1'b0));
    chk($sformatf("v%0d done dm_req", idx), 32'(dm_req), 32'(1'b0));
    chk($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(v.stalls));
    if (is_load) begin
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d scoreboard empty", idx), 32'd1, 32'd0);
      end else begin
        exp_out = sb_q.pop_front();
        chk($sformatf("v%0d DM_OUT", idx), DM_OUT, exp_out);
        last_out = exp_out;
      end
    end else begin
      chk($sformatf("v%0d DM_OUT held", idx), DM_OUT, last_out);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              rd   wr   f3      addr          sd            dly   rdata         mis  we       wdata         daddr         dout          st
    vecs[0]  = '{1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        4'd0,32'hDEADBEEF,1'b0,4'b0000,32'h0,        32'h0000_0100,32'hDEADBEEF,4'd2};
    vecs[1]  = '{1'b1,1'b0,3'b000,32'h0000_0103,32'h0,        4'd0,32'h80112233,1'b0,4'b0000,32'h0,        32'h0000_0100,32'h00000080,4'd2};
    vecs[2]  = '{1'b1,1'b0,3'b001,32'h0000_0102,32'h0,        4'd0,32'h80112233,1'b0,4'b0000,32'h0,        32'h0000_0100,32'h00008011,4'd2};
    vecs[3]  = '{1'b0,1'b1,3'b000,32'h0000_0201,32'h000000A5, 4'd3,32'h0,       1'b0,4'b0010,32'hA5A5A5A5,32'h0000_0200,32'h0,       4'd4};
    vecs[4]  = '{1'b0,1'b1,3'b001,32'h0000_0302,32'hFFFF1234, 4'd0,32'h0,       1'b0,4'b1100,32'h12341234,32'h0000_0300,32'h0,       4'd1};
    vecs[5]  = '{1'b0,1'b1,3'b010,32'h0000_0404,32'hCAFEF00D, 4'd1,32'h0,       1'b0,4'b1111,32'hCAFEF00D,32'h0000_0404,32'h0,       4'd2};
    vecs[6]  = '{1'b1,1'b0,3'b010,32'h0000_0102,32'h0,        4'd0,32'h0,       1'b1,4'b0000,32'h0,        32'h0,        32'h0,       4'd0};
    vecs[7]  = '{1'b0,1'b1,3'b001,32'h0000_0103,32'h00000001, 4'd0,32'h0,       1'b1,4'b0000,32'h0,        32'h0,        32'h0,       4'd0};
    vecs[8]  = '{1'b1,1'b0,3'b011,32'h0000_0000,32'h0,        4'd0,32'h0,       1'b1,4'b0000,32'h0,        32'h0,        32'h0,       4'd0};
    vecs[9]  = '{1'b1,1'b0,3'b101,32'h0000_0500,32'h0,        4'd2,32'hA1B2C3D4,1'b0,4'b0000,32'h0,        32'h0000_0500,32'hA1B2C3D4,4'd4};
    vecs[10] = '{1'b1,1'b1,3'b000,32'h0000_0602,32'h0000003C, 4'd0,32'h0,       1'b0,4'b0100,32'h3C3C3C3C,32'h0000_0600,32'h0,       4'd1};
    vecs[11] = '{1'b1,1'b0,3'b100,32'h0000_0601,32'h0,        4'd1,32'h11223344,1'b0,4'b0000,32'h0,        32'h0000_0600,32'h00112233,4'd3};
    vecs[12] = '{1'b0,1'b0,3'b010,32'h0000_0700,32'h0,        4'd0,32'h0,       1'b0,4'b0000,32'h0,        32'h0,        32'h0,       4'd0};

    idle_inputs();
    last_out = '0;
    rst = 1'b1;
    #1;
    chk("reset dm_req", 32'(dm_req), 32'(1'b0));
    chk("reset stall_mem", 32'(stall_mem), 32'(1'b0));
    chk("reset DM_OUT", DM_OUT, 32'h0);
    chk("reset dm_we", 32'(dm_we), 32'(4'b0000));
    // A pending aligned access must not request while reset is held
    mem_rd_MEM = 1'b1; funct3_MEM = 3'b010; addr_MEM = 32'h100;
    #1;
    chk("reset gated dm_req", 32'(dm_req), 32'(1'b0));
    chk("reset gated stall", 32'(stall_mem), 32'(1'b0));
    mem_rd_MEM = 1'b0; funct3_MEM = 3'b000; addr_MEM = 32'h102;
    mem_wr_MEM = 1'b1; funct3_MEM = 3'b010;
    #1;
    chk("reset gated misalign", 32'(misalign_exc), 32'(1'b0));
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Reset while waiting for a response, then a stale rvalid
    @(negedge clk);
    mem_rd_MEM = 1'b1; funct3_MEM = 3'b010; addr_MEM = 32'h100; dm_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dm_gnt = 1'b0;
    #1;
    chk("abort resp stall", 32'(stall_mem), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("abort rst stall", 32'(stall_mem), 32'(1'b0));
    chk("abort rst dm_req", 32'(dm_req), 32'(1'b0));
    chk("abort rst DM_OUT", DM_OUT, 32'h0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    dm_rvalid = 1'b0; dm_rdata = '0;
    #1;
    chk("late rvalid DM_OUT", DM_OUT, 32'h0);
    chk("late rvalid stall", 32'(stall_mem), 32'(1'b0));
    chk("late rvalid dm_req", 32'(dm_req), 32'(1'b0));
    last_out = '0;
    run_vec(100, vecs[0]);
    run_vec(101, vecs[3]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
